// File: rtl/aes_decrypt_iterative.sv
// aes_decrypt_iterative: one-round-per-clock AES-128 inverse cipher; define AES_DEC_KEY_LATCH_EN to register all_keys at accept.
module aes_decrypt_iterative (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  ciphertext,
  input  logic [1407:0] all_keys,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  plaintext
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
  state_t r_state, w_next;
  logic [127:0] r_st, r_pt, w_sb, w_rk_sel, w_mix;
  logic [3:0] r_rnd;
  logic [10:0][127:0] w_rk;
  logic w_accept;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction

  // inverse affine, then multiplicative inverse as x^254 (maps 0 to 0)
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] a, x2, x3, x6, x12, x15, x240;
    a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    x2 = gm(a, a);
    x3 = gm(x2, a);
    x6 = gm(x3, x3);
    x12 = gm(x6, x6);
    x15 = gm(x12, x3);
    x240 = gm(x15, x15);
    x240 = gm(x240, x240);
    x240 = gm(x240, x240);
    x240 = gm(x240, x240);
    return gm(gm(x240, x12), x2);
  endfunction

  function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r)&3)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [31:0] cf;
    cf = 32'h0e0b0d09;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        for (int j = 0; j < 4; j++)
          o[127-8*(4*c+r) -: 8] = o[127-8*(4*c+r) -: 8] ^ gm(cf[31-8*((j-r)&3) -: 8], s[127-8*(4*c+j) -: 8]);
    return o;
  endfunction

`ifdef AES_DEC_KEY_LATCH_EN
  logic [1407:0] r_keys;
  always_ff @(posedge clk)
    if (!rst_n) r_keys <= '0;
    else if (w_accept) r_keys <= all_keys;
  assign w_rk = r_keys;
`else
  assign w_rk = all_keys;
`endif

  // key0 sits in the top slice, so slot 10-rnd is round key rnd; rnd is 0 in FINAL
  assign w_rk_sel = w_rk[4'd10 - r_rnd];
  assign w_sb = inv_sr_sb(r_st);
  assign w_mix = inv_mix(w_sb ^ w_rk_sel);
  assign w_accept = in_valid & in_ready;
  assign plaintext = r_pt;

  always_ff @(posedge clk)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    in_ready = r_state == IDLE;
    out_valid = r_state == DONE;
    w_next = r_state == IDLE  ? (in_valid ? ROUND : IDLE) :
             r_state == ROUND ? (r_rnd == 4'd1 ? FINAL : ROUND) :
             r_state == FINAL ? DONE : (out_ready ? IDLE : DONE);
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      r_st <= '0;
      r_rnd <= '0;
      r_pt <= '0;
    end else if (w_accept) begin
      r_st <= ciphertext ^ all_keys[127:0];
      r_rnd <= 4'd9;
    end else if (r_state == ROUND) begin
      r_st <= w_mix;
      r_rnd <= r_rnd - 4'd1;
    end else if (r_state == FINAL) r_pt <= w_sb ^ w_rk_sel;
endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// tb_aes_decrypt_iterative: directed FIPS-197 vectors with a plaintext scoreboard.
module tb_aes_decrypt_iterative;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, in_ready, out_valid;
  logic [127:0] ciphertext = '0, plaintext;
  logic [1407:0] all_keys = '0, ks_b, ks_c;
  logic [127:0] sb_q[$];
  int n_vec = 0, n_err = 0, cyc = 0, lat, t1;

  always #5 clk = ~clk;

  aes_decrypt_iterative dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .all_keys(all_keys), .out_valid(out_valid),
    .out_ready(out_ready), .plaintext(plaintext)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] fsbox(input logic [7:0] x);
    logic [7:0] v;
    v = '0;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1407:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {fsbox(t[23:16]), fsbox(t[15:8]), fsbox(t[7:0]), fsbox(t[31:24])} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [127:0] ct, input logic [1407:0] keys, input logic [127:0] exp);
    ciphertext = ct;
    all_keys = keys;
    in_valid = 1;
    chk("accept_ready", 128'(in_ready), 128'd1);
    tick;
    in_valid = 0;
    sb_q.push_back(exp);
  endtask

  task automatic wait_out(inout int l);
    while (out_valid !== 1'b1 && l < 40) begin
      tick;
      l++;
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [127:0] e;
    e = sb_q.size() > 0 ? sb_q.pop_front() : 128'hx;
    chk(tag, plaintext, e);
  endtask

  initial begin
    ks_b = expand(KEY_B);
    ks_c = expand(KEY_C);
    tick;
    tick;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_plaintext", plaintext, 128'd0);
    rst_n = 1;
    tick;
    // App. B with a busy-time input and 20 cycles of backpressure
    send(CT_B, ks_b, PT_B);
    chk("busy_in_ready", 128'(in_ready), 128'd0);
    lat = 0;
    tick;
    tick;
    lat = 2;
    ciphertext = CT_C;
    in_valid = 1;
    tick;
    tick;
    lat = 4;
    in_valid = 0;
    ciphertext = CT_B;
    wait_out(lat);
    chk("latency_b", 128'(lat), 128'd10);
    pop_chk("fips_b");
    repeat (20) begin
      tick;
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_plaintext", plaintext, PT_B);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1;
    tick;
    out_ready = 0;
    chk("release_in_ready", 128'(in_ready), 128'd1);
    chk("release_out_valid", 128'(out_valid), 128'd0);
    // back-to-back B then C.1 with out_ready tied high
    out_ready = 1;
    send(CT_B, ks_b, PT_B);
    lat = 0;
    wait_out(lat);
    chk("latency_b2b_b", 128'(lat), 128'd10);
    t1 = cyc;
    pop_chk("b2b_b");
    ciphertext = CT_C;
    all_keys = ks_c;
    in_valid = 1;
    tick;
    chk("b2b_in_ready", 128'(in_ready), 128'd1);
    chk("b2b_out_valid_low", 128'(out_valid), 128'd0);
    tick;
    in_valid = 0;
    sb_q.push_back(PT_C);
    lat = 0;
    wait_out(lat);
    chk("latency_b2b_c", 128'(lat), 128'd10);
    chk("b2b_spacing", 128'(cyc - t1), 128'd12);
    pop_chk("b2b_c1");
    tick;
    out_ready = 0;
    // reset at T+5 abandons the block
    send(CT_B, ks_b, PT_B);
    repeat (4) tick;
    rst_n = 0;
    tick;
    rst_n = 1;
    void'(sb_q.pop_back());
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_plaintext", plaintext, 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'd1);
    repeat (12) begin
      tick;
      chk("midrst_quiet", 128'(out_valid), 128'd0);
    end
    send(CT_B, ks_b, PT_B);
    lat = 0;
    wait_out(lat);
    chk("latency_post_rst", 128'(lat), 128'd10);
    pop_chk("post_rst_b");
    out_ready = 1;
    tick;
    out_ready = 0;
    // App. C.1; with the key latch the source keys are wiped after acceptance
    send(CT_C, ks_c, PT_C);
`ifdef AES_DEC_KEY_LATCH_EN
    all_keys = '0;
`endif
    lat = 0;
    wait_out(lat);
    chk("latency_c1", 128'(lat), 128'd10);
    pop_chk("fips_c1");
    out_ready = 1;
    tick;
    out_ready = 0;
    chk("final_in_ready", 128'(in_ready), 128'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
